// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned 32x32 shift-add multiplier that borrows the shared ALU adder.
// Optional MUL_EARLY_TERM_EN: stop once the remaining multiplier bits are zero.
module alu_mul_seq #(
  parameter int ITERATIONS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        mul_overflow,
  output logic        alu_enable_execute,
  output logic [5:0]  alu_opcode,
  output logic [4:0]  alu_sub_op_base,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow
);
  // Encodings of `TY_BASE / `ADD from def_opcode.v.
  localparam logic [5:0] OPC_TY_BASE = 6'h0c;
  localparam logic [4:0] SUB_ADD     = 5'h03;
  localparam int         CW          = $clog2(ITERATIONS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [31:0]   mcand, mulr, acc, acc_next;
  logic [CW-1:0] count;
  logic          ovf, ovf_next, add_en, last_iter;

  // The ALU's signed overflow flag means nothing for an unsigned multiply.
  logic unused_alu_ovf;
  assign unused_alu_ovf = alu_overflow;

  assign add_en             = (state == RUN) && mulr[0];
  assign alu_enable_execute = add_en;
  assign alu_opcode         = add_en ? OPC_TY_BASE : 6'h0;
  assign alu_sub_op_base    = add_en ? SUB_ADD : 5'h0;
  assign alu_src1           = add_en ? acc : 32'h0;
  assign alu_src2           = add_en ? mcand : 32'h0;

  assign acc_next = add_en ? alu_result : acc;
  // Overflow: either the add wrapped, or a multiplicand bit is shifted out
  // while multiplier bits remain that would still multiply it.
  assign ovf_next = ovf | (add_en && (alu_result < acc)) |
                    (mcand[31] && (mulr[31:1] != 31'h0));

`ifdef MUL_EARLY_TERM_EN
  assign last_iter = (count == CW'(ITERATIONS - 1)) || (mulr[31:1] == 31'h0);
`else
  assign last_iter = (count == CW'(ITERATIONS - 1));
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      mcand        <= '0;
      mulr         <= '0;
      acc          <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      result       <= '0;
      mul_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= op_a;
            mulr  <= op_b;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
`ifdef MUL_EARLY_TERM_EN
            if (op_b == 32'h0) begin
              state        <= DONE;
              result       <= '0;
              mul_overflow <= 1'b0;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mulr  <= mulr >> 1;
          count <= count + 1'b1;
          ovf   <= ovf_next;
          if (last_iter) begin
            state        <= DONE;
            result       <= acc_next;
            mul_overflow <= ovf_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
